// File: rtl/wide_reg_bank_if.sv
`default_nettype none
// ============================================================================
// wide_reg_bank_if : VME-style memory bus between slave decoder and reg bank
// rev 1.0
// ============================================================================
interface wide_reg_bank_if #(
   parameter int AW = 1
);
   logic [AW+1:2] VMEAddr;
   logic [31:0]   VMEWrData;
   logic [31:0]   VMERdData;
   logic          VMERdMem;
   logic          VMEWrMem;
   logic          VMERdDone;
   logic          VMEWrDone;

   modport master (
      output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
      input  VMERdData, VMERdDone, VMEWrDone
   );

   modport slave (
      input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
      output VMERdData, VMERdDone, VMEWrDone
   );
endinterface
`default_nettype wire

// File: rtl/wide_reg_bank.sv
`default_nettype none
// ============================================================================
// wide_reg_bank : multi-word control registers with atomic staging/shadow,
// autoclear pulse registers and commit strobes.   rev 1.0
// ============================================================================
module wide_reg_bank #(
   parameter int                N_REGS    = 2,
   parameter int                WORDS     = 2,
   parameter bit                ATOMIC    = 1'b1,
   parameter logic [N_REGS-1:0] AUTOCLEAR = '0
) (
   input  logic                       Clk,
   input  logic                       Rst,
   wide_reg_bank_if.slave             vme,
   output logic [N_REGS*WORDS*32-1:0] regs_o,
   output logic [N_REGS-1:0]          wr_strobe_o
);
   localparam int AW        = (N_REGS * WORDS > 1) ? $clog2(N_REGS * WORDS) : 1;
   localparam bit USE_STAGE = ATOMIC && (WORDS > 1);

   logic          wr_vld_q,  wr_vld_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]   wr_data_q, wr_data_d;
   logic          rd_done_q, rd_done_d;
   logic [31:0]   rd_data_q, rd_data_d;

   logic [31:0]   reg_q    [N_REGS][WORDS];
   logic [31:0]   reg_d    [N_REGS][WORDS];
   logic [31:0]   stage_q  [N_REGS][WORDS];
   logic [31:0]   stage_d  [N_REGS][WORDS];
   logic [31:0]   shadow_q [N_REGS][WORDS];
   logic [31:0]   shadow_d [N_REGS][WORDS];

   logic [N_REGS-1:0] wr_strobe;

   always_comb begin
      wr_vld_d  = vme.VMEWrMem;
      wr_addr_d = vme.VMEAddr;
      wr_data_d = vme.VMEWrData;
      rd_done_d = vme.VMERdMem;
   end

   // Write decode happens one cycle after capture; autoclear registers fall
   // back to zero every cycle that carries no commit.
   always_comb begin
      reg_d     = reg_q;
      stage_d   = stage_q;
      wr_strobe = '0;
      for (int i = 0; i < N_REGS; i++) begin
         if (AUTOCLEAR[i]) begin
            for (int k = 0; k < WORDS; k++) begin
               reg_d[i][k] = '0;
            end
         end
      end
      if (wr_vld_q) begin
         for (int i = 0; i < N_REGS; i++) begin
            for (int k = 0; k < WORDS; k++) begin
               if (wr_addr_q == AW'(i * WORDS + k)) begin
                  if (USE_STAGE && (k != WORDS - 1)) begin
                     stage_d[i][k] = wr_data_q;
                  end else begin
                     if (USE_STAGE) begin
                        for (int j = 0; j < WORDS - 1; j++) begin
                           reg_d[i][j] = stage_q[i][j];
                        end
                     end
                     reg_d[i][k]  = wr_data_q;
                     wr_strobe[i] = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Word 0 reads the live value and freezes the remaining words so a
   // multi-word read cannot tear across a commit.
   always_comb begin
      rd_data_d = rd_data_q;
      shadow_d  = shadow_q;
      if (vme.VMERdMem) begin
         rd_data_d = '0;
         for (int i = 0; i < N_REGS; i++) begin
            for (int k = 0; k < WORDS; k++) begin
               if (vme.VMEAddr == AW'(i * WORDS + k)) begin
                  if (USE_STAGE && (k != 0)) begin
                     rd_data_d = shadow_q[i][k];
                  end else begin
                     rd_data_d = AUTOCLEAR[i] ? 32'h0 : reg_q[i][k];
                  end
                  if (USE_STAGE && (k == 0)) begin
                     for (int j = 1; j < WORDS; j++) begin
                        shadow_d[i][j] = AUTOCLEAR[i] ? 32'h0 : reg_q[i][j];
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_done_q <= 1'b0;
         rd_data_q <= '0;
         reg_q     <= '{default: '0};
         stage_q   <= '{default: '0};
         shadow_q  <= '{default: '0};
      end else begin
         wr_vld_q  <= wr_vld_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_done_q <= rd_done_d;
         rd_data_q <= rd_data_d;
         reg_q     <= reg_d;
         stage_q   <= stage_d;
         shadow_q  <= shadow_d;
      end
   end

   // Acks and strobes are masked during reset so an in-flight request is dropped.
   assign vme.VMEWrDone = wr_vld_q & ~Rst;
   assign vme.VMERdDone = rd_done_q & ~Rst;
   assign vme.VMERdData = rd_data_q;
   assign wr_strobe_o   = wr_strobe & {N_REGS{~Rst}};

   generate
      for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
         for (genvar gk = 0; gk < WORDS; gk++) begin : g_word
            assign regs_o[gi*WORDS*32 + (WORDS-1-gk)*32 +: 32] = reg_q[gi][gk];
         end
      end
   endgenerate
endmodule
`default_nettype wire
